// File: rtl/edge_detect_moore_mc_pkg.sv
// Shared types for the multi-channel Moore edge detector.
// FSM state encoding and runtime edge-mode encoding.
package edge_detect_pkg;

  typedef enum logic [1:0] {
    S_LO   = 2'b00,
    S_RISE = 2'b01,
    S_HI   = 2'b10,
    S_FALL = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    EM_RISE = 2'b00,
    EM_FALL = 2'b01,
    EM_BOTH = 2'b10,
    EM_OFF  = 2'b11
  } edge_mode_t;

endpackage

// File: rtl/edge_detect_moore_mc_if.sv
// Bus bundle of the edge detector: in/mode/cnt_clr toward the block,
// out/edge_cnt/dbg_state from it. master = driver side, slave = detector.
interface edge_detect_moore_mc_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
);

  logic [N_CH-1:0]       in;
  logic [1:0]            mode;
  logic                  cnt_clr;
  logic [N_CH-1:0]       out;
  logic [N_CH*CNT_W-1:0] edge_cnt;
  logic [2*N_CH-1:0]     dbg_state;

  modport master (
    output in, mode, cnt_clr,
    input  out, edge_cnt, dbg_state
  );

  modport slave (
    input  in, mode, cnt_clr,
    output out, edge_cnt, dbg_state
  );

endinterface

// File: rtl/edge_detect_moore_mc_chan.sv
// One channel: debounce filter, 4-state Moore FSM, saturating counter.
// in_i raw level, mode_i registered mode, clr_i counter clear; pulse/cnt/state out.
module edge_detect_chan
  import edge_detect_pkg::*;
#(
  parameter int DEB_CYCLES = 0,
  parameter int CNT_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_i,
  input  edge_mode_t       mode_i,
  input  logic             clr_i,
  output logic             pulse_o,
  output logic [CNT_W-1:0] cnt_o,
  output state_t           state_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             filt;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  generate
    if (DEB_CYCLES == 0) begin : g_bypass
      assign filt = in_i;
    end else begin : g_deb
      localparam int DW =
        (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
      localparam logic [DW-1:0] LAST = DW'(DEB_CYCLES - 1);

      logic          filt_q, filt_d;
      logic [DW-1:0] deb_q, deb_d;

      // Any sample matching the accepted level restarts the run.
      always_comb begin
        filt_d = filt_q;
        deb_d  = '0;
        if (in_i != filt_q) begin
          if (deb_q == LAST) filt_d = in_i;
          else               deb_d  = deb_q + DW'(1);
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          filt_q <= 1'b0;
          deb_q  <= '0;
        end else begin
          filt_q <= filt_d;
          deb_q  <= deb_d;
        end
      end

      assign filt = filt_q;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_LO;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LO:   state_d = filt ? S_RISE : S_LO;
      S_RISE: state_d = filt ? S_HI   : S_FALL;
      S_HI:   state_d = filt ? S_HI   : S_FALL;
      S_FALL: state_d = filt ? S_RISE : S_LO;
      default: state_d = S_LO;
    endcase
  end

  always_comb begin
    pulse_o = 1'b0;
    unique case (1'b1)
      (state_q == S_RISE):
        pulse_o = (mode_i == EM_RISE) || (mode_i == EM_BOTH);
      (state_q == S_FALL):
        pulse_o = (mode_i == EM_FALL) || (mode_i == EM_BOTH);
      default: pulse_o = 1'b0;
    endcase
  end

  // Clear takes priority over a same-cycle pulse.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (pulse_o && cnt_q != CNT_MAX)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o   = cnt_q;
  assign state_o = state_q;

endmodule

// File: rtl/edge_detect_moore_mc.sv
// Multi-channel Moore edge detector top: registers mode, fans out channels.
// clk/rst plain; bus (slave) carries in/mode/cnt_clr and out/edge_cnt/dbg_state.
module edge_detect_moore_mc
  import edge_detect_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DEB_CYCLES = 0,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  edge_detect_moore_mc_if.slave bus
);

  edge_mode_t mode_q, mode_d;

  logic [N_CH-1:0]       pulse;
  logic [N_CH*CNT_W-1:0] cnt;
  logic [2*N_CH-1:0]     dbg;

  assign mode_d = edge_mode_t'(bus.mode);

  always_ff @(posedge clk) begin
    if (rst) mode_q <= EM_RISE;
    else     mode_q <= mode_d;
  end

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      state_t st;

      edge_detect_chan #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
      ) u_chan (
        .clk_i   (clk),
        .rst_i   (rst),
        .in_i    (bus.in[i]),
        .mode_i  (mode_q),
        .clr_i   (bus.cnt_clr),
        .pulse_o (pulse[i]),
        .cnt_o   (cnt[i*CNT_W +: CNT_W]),
        .state_o (st)
      );

      assign dbg[2*i +: 2] = st;
    end
  endgenerate

  assign bus.out       = pulse;
  assign bus.edge_cnt  = cnt;
  assign bus.dbg_state = dbg;

endmodule

// File: tb/tb_edge_detect_moore_mc.sv
// Directed bench for edge_detect_moore_mc: three instances
// (D=0/W=8, D=3/W=8, D=0/W=2) driven with hand-checked vectors.
module tb_edge_detect_moore_mc;

  logic clk;
  logic rst_a, rst_b, rst_c;
  int   checks;
  int   failures;

  edge_detect_moore_mc_if #(.N_CH(4), .CNT_W(8)) ifa ();
  edge_detect_moore_mc_if #(.N_CH(4), .CNT_W(8)) ifb ();
  edge_detect_moore_mc_if #(.N_CH(4), .CNT_W(2)) ifc ();

  edge_detect_moore_mc #(
    .N_CH(4), .DEB_CYCLES(0), .CNT_W(8)
  ) u_a (.clk(clk), .rst(rst_a), .bus(ifa));

  edge_detect_moore_mc #(
    .N_CH(4), .DEB_CYCLES(3), .CNT_W(8)
  ) u_b (.clk(clk), .rst(rst_b), .bus(ifb));

  edge_detect_moore_mc #(
    .N_CH(4), .DEB_CYCLES(0), .CNT_W(2)
  ) u_c (.clk(clk), .rst(rst_c), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  bit t1_in  [8] = '{0, 1, 1, 0, 0, 1, 1, 0};
  int t1_st  [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  bit t1_out [8] = '{0, 1, 0, 0, 0, 1, 0, 0};

  bit t2_in  [6] = '{0, 1, 1, 0, 1, 0};
  bit t2_out [6] = '{0, 1, 0, 1, 1, 1};

  bit t4_in  [6] = '{0, 1, 0, 0, 1, 0};
  int t4_md  [6] = '{1, 1, 1, 3, 3, 3};
  int t4_st  [6] = '{0, 1, 3, 0, 1, 3};
  bit t4_out [6] = '{0, 0, 1, 0, 0, 0};

  bit t4b_in [3] = '{1, 0, 0};
  int t4b_st [3] = '{1, 3, 0};
  bit t4b_out[3] = '{1, 1, 0};

  initial begin
    checks   = 0;
    failures = 0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    ifa.in = '0; ifa.mode = 2'b00; ifa.cnt_clr = 1'b0;
    ifb.in = '0; ifb.mode = 2'b00; ifb.cnt_clr = 1'b0;
    ifc.in = '0; ifc.mode = 2'b00; ifc.cnt_clr = 1'b0;
    tick();
    tick();

    check("rst_out", ifa.out, 0);
    check("rst_dbg", ifa.dbg_state, 0);
    check("rst_cnt", ifa.edge_cnt, 0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // 1: rise mode, ch0
    for (int i = 0; i < 8; i++) begin
      ifa.in[0] = t1_in[i];
      tick();
      check($sformatf("t1_st%0d", i),
            ifa.dbg_state[1:0], t1_st[i]);
      check($sformatf("t1_out%0d", i),
            ifa.out[0], t1_out[i]);
    end
    ifa.in[0] = 1'b0;
    tick();
    check("t1_cnt", ifa.edge_cnt[7:0], 2);

    // 2: both mode, ch1
    ifa.mode = 2'b10;
    tick();
    for (int i = 0; i < 6; i++) begin
      ifa.in[1] = t2_in[i];
      tick();
      check($sformatf("t2_out%0d", i),
            ifa.out[1], t2_out[i]);
    end
    ifa.in[1] = 1'b0;
    tick();
    check("t2_cnt", ifa.edge_cnt[15:8], 4);

    // 4: fall mode then off, ch2
    for (int i = 0; i < 6; i++) begin
      ifa.in[2] = t4_in[i];
      ifa.mode  = 2'(t4_md[i]);
      tick();
      check($sformatf("t4_st%0d", i),
            ifa.dbg_state[5:4], t4_st[i]);
      check($sformatf("t4_out%0d", i),
            ifa.out[2], t4_out[i]);
    end
    check("t4_cnt_hold", ifa.edge_cnt[23:16], 1);
    ifa.mode  = 2'b10;
    ifa.in[2] = 1'b1;
    #1;
    check("t4_mode_lag", ifa.out[2], 0);
    for (int i = 0; i < 3; i++) begin
      ifa.in[2] = t4b_in[i];
      tick();
      check($sformatf("t4b_st%0d", i),
            ifa.dbg_state[5:4], t4b_st[i]);
      check($sformatf("t4b_out%0d", i),
            ifa.out[2], t4b_out[i]);
    end
    check("t4_cnt_all", ifa.edge_cnt, 32'h0003_0402);

    // 6: reset while in S_RISE, ch3
    ifa.mode = 2'b00;
    tick();
    ifa.in[3] = 1'b1;
    tick();
    check("t6_pre_st", ifa.dbg_state[7:6], 1);
    check("t6_pre_out", ifa.out[3], 1);
    rst_a = 1'b1;
    tick();
    check("t6_rst_out", ifa.out[3], 0);
    check("t6_rst_dbg", ifa.dbg_state, 0);
    check("t6_rst_cnt", ifa.edge_cnt, 0);
    rst_a = 1'b0;
    tick();
    check("t6_post_st", ifa.dbg_state[7:6], 1);
    check("t6_post_out", ifa.out[3], 1);
    tick();
    check("t6_hi_out", ifa.out[3], 0);
    check("t6_cnt", ifa.edge_cnt[31:24], 1);

    // 3: debounce D=3, ch2
    for (int i = 0; i < 3; i++) begin
      ifb.in[2] = (i < 2);
      tick();
      check($sformatf("t3_gl_st%0d", i),
            ifb.dbg_state[5:4], 0);
      check($sformatf("t3_gl_out%0d", i),
            ifb.out[2], 0);
    end
    for (int i = 0; i < 3; i++) begin
      ifb.in[2] = 1'b1;
      tick();
      check($sformatf("t3_hi_st%0d", i),
            ifb.dbg_state[5:4], 0);
    end
    tick();
    check("t3_rise_st", ifb.dbg_state[5:4], 1);
    check("t3_rise_out", ifb.out[2], 1);
    tick();
    check("t3_hi_out", ifb.out[2], 0);
    check("t3_cnt", ifb.edge_cnt[23:16], 1);

    // 5: saturation and clear, CNT_W=2, ch3
    for (int i = 0; i < 5; i++) begin
      ifc.in[3] = 1'b1;
      tick();
      check($sformatf("t5_pulse%0d", i), ifc.out[3], 1);
      ifc.in[3] = 1'b0;
      tick();
    end
    check("t5_sat", ifc.edge_cnt[7:6], 3);
    ifc.in[3] = 1'b1;
    tick();
    check("t5_clr_pre", ifc.out[3], 1);
    ifc.cnt_clr = 1'b1;
    tick();
    check("t5_clr", ifc.edge_cnt[7:6], 0);
    ifc.cnt_clr = 1'b0;
    tick();
    check("t5_clr_hold", ifc.edge_cnt[7:6], 0);
    check("t5_hi_st", ifc.dbg_state[7:6], 2);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
